// File: rtl/up_dn_cmd_sequencer.sv
// Command master for an up/down counter: NOP/LOAD/UP n/DOWN n in, Load/IN/Up/Down out; cmd_ready only when idle.
// Done one cycle after the last strobe, sat with done on early stop; define UDSEQ_PACE_EN for PACE idle cycles between steps.
module up_dn_cmd_sequencer #(
  parameter int WIDTH = 5
`ifdef UDSEQ_PACE_EN
  , parameter int PACE = 2
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             High,
  input  logic             Low,
  output logic [WIDTH-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
`ifdef UDSEQ_PACE_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  // Holds the LOAD value, or the remaining step count for UP/DOWN.
  logic [WIDTH-1:0] rem;
  logic             dir_up;
  logic             sat_r;
  logic             accept;
  logic             step_fire;
  logic             sat_set;
  logic             limit;

`ifdef UDSEQ_PACE_EN
  localparam int GW = (PACE > 1) ? $clog2(PACE + 1) : 1;
  logic [GW-1:0] gap_cnt;
`endif

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    step_fire = 1'b0;
    sat_set   = 1'b0;
    limit     = dir_up ? High : Low;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          case (cmd_op)
            OP_LOAD:        nxt = S_LOAD;
            OP_UP, OP_DOWN: nxt = (cmd_arg == '0) ? S_DONE : S_STEP;
            default:        nxt = S_DONE;
          endcase
        end
      end
      S_LOAD: nxt = S_DONE;
      S_STEP: begin
        // Limit flag comes from the counter's registered state, so no step is issued at max/0.
        if (limit) begin
          sat_set = 1'b1;
          nxt     = S_DONE;
        end else begin
          step_fire = 1'b1;
          if (rem == WIDTH'(1)) begin
            nxt = S_DONE;
          end else begin
`ifdef UDSEQ_PACE_EN
            nxt = S_GAP;
`else
            nxt = S_STEP;
`endif
          end
        end
      end
`ifdef UDSEQ_PACE_EN
      S_GAP: begin
        if (gap_cnt == '0) begin
          nxt = S_STEP;
        end
      end
`endif
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      rem    <= '0;
      dir_up <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        rem    <= cmd_arg;
        dir_up <= (cmd_op == OP_UP);
      end else if (step_fire) begin
        rem <= rem - WIDTH'(1);
      end
      if (sat_set) begin
        sat_r <= 1'b1;
      end else if (state == S_DONE) begin
        sat_r <= 1'b0;
      end
    end
  end

`ifdef UDSEQ_PACE_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gap_cnt <= '0;
    end else if (step_fire) begin
      gap_cnt <= GW'(PACE - 1);
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end
`endif

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign Load      = (state == S_LOAD);
  assign IN        = Load ? rem : '0;
  assign Up        = (state == S_STEP) &&  dir_up && !High;
  assign Down      = (state == S_STEP) && !dir_up && !Low;
  assign done      = (state == S_DONE);
  assign sat       = done && sat_r;

endmodule
